// File: rtl/sm4_arb_pkg.sv
// Shared types and constants for the SM4 Ethernet arbiter.
//   arb_state_e : 3-bit FSM state encoding (IDLE, LOAD, SETTLE, XFER, DRAIN)
//   sm4_cfg_t   : engine configuration {key, sel}, SM4_CFG_W bits
//   axis_beat_t : one byte-wide AXI-Stream beat (without tready)
package sm4_arb_pkg;

  localparam int unsigned SM4_KEY_W   = 128;
  localparam int unsigned SM4_CFG_W   = SM4_KEY_W + 1;
  localparam int unsigned AXIS_DATA_W = 8;
  localparam int unsigned AXIS_USER_W = 8;
  localparam int unsigned SETTLE_CNT_W = 8;
  localparam int unsigned DRAIN_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_XFER   = 3'd3,
    ST_DRAIN  = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [SM4_KEY_W-1:0] key;
    logic                 sel;
  } sm4_cfg_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic [AXIS_USER_W-1:0] tuser;
  } axis_beat_t;

endpackage

// File: rtl/sm4_rr_arb2.sv
// Two-requester round-robin picker, purely combinational.
//   req        : request vector, bit N = requester N
//   last_grant : requester served most recently
//   grant      : chosen requester index
//   grant_vld  : at least one request present
module sm4_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_vld
);

  // A lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_vld = |req;
    grant     = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sm4_eth_arbiter.sv
// Packet-level scheduler sharing one SM4 byte-stream engine between two
// Ethernet requesters. Grants per packet round-robin, reloads the engine key
// only when {key, sel} differs from what the engine already holds, forwards
// the owner's input packet and routes engine output back until its tlast.
//   clk, rst_n             : clock, async active-low reset
//   sN_key, sN_sel         : per-requester configuration, sampled at grant
//   sN_axis_*              : requester input streams (tready is an output)
//   mN_axis_*              : requester result streams, no backpressure
//   e_sm4_vld/key/sel      : registered engine key-load controls
//   e_s_axis_*             : engine input stream
//   e_m_axis_*             : engine output stream
//   owner, busy            : granted requester, FSM not idle
//   timeout_err            : one-cycle pulse when draining gives up
module sm4_eth_arbiter
  import sm4_arb_pkg::*;
#(
  parameter int unsigned KEY_SETTLE    = 4,
  parameter int unsigned DRAIN_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SM4_KEY_W-1:0]   s0_key,
  input  logic                   s0_sel,
  input  logic [SM4_KEY_W-1:0]   s1_key,
  input  logic                   s1_sel,
  input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
  input  logic                   s0_axis_tvalid,
  input  logic                   s0_axis_tlast,
  input  logic [AXIS_USER_W-1:0] s0_axis_tuser,
  output logic                   s0_axis_tready,
  input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
  input  logic                   s1_axis_tvalid,
  input  logic                   s1_axis_tlast,
  input  logic [AXIS_USER_W-1:0] s1_axis_tuser,
  output logic                   s1_axis_tready,
  output logic [AXIS_DATA_W-1:0] m0_axis_tdata,
  output logic                   m0_axis_tvalid,
  output logic                   m0_axis_tlast,
  output logic [AXIS_USER_W-1:0] m0_axis_tuser,
  output logic [AXIS_DATA_W-1:0] m1_axis_tdata,
  output logic                   m1_axis_tvalid,
  output logic                   m1_axis_tlast,
  output logic [AXIS_USER_W-1:0] m1_axis_tuser,
  output logic                   e_sm4_vld,
  output logic [SM4_KEY_W-1:0]   e_sm4_key,
  output logic                   e_sm4_sel,
  output logic [AXIS_DATA_W-1:0] e_s_axis_tdata,
  output logic                   e_s_axis_tvalid,
  output logic                   e_s_axis_tlast,
  output logic [AXIS_USER_W-1:0] e_s_axis_tuser,
  input  logic                   e_s_axis_tready,
  input  logic [AXIS_DATA_W-1:0] e_m_axis_tdata,
  input  logic                   e_m_axis_tvalid,
  input  logic                   e_m_axis_tlast,
  input  logic [AXIS_USER_W-1:0] e_m_axis_tuser,
  output logic                   owner,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(KEY_SETTLE - 1);
  localparam logic [DRAIN_CNT_W-1:0]  DRAIN_LAST  = DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  sm4_cfg_t                cfg_q, cfg_d;
  sm4_cfg_t                loaded_cfg_q, loaded_cfg_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                    e_sm4_vld_q, e_sm4_vld_d;
  logic [SM4_KEY_W-1:0]    e_sm4_key_q, e_sm4_key_d;
  logic                    e_sm4_sel_q, e_sm4_sel_d;
  logic                    busy_q, busy_d;
  logic                    timeout_err_q, timeout_err_d;

  logic       grant, grant_vld;
  sm4_cfg_t   grant_cfg;
  axis_beat_t src_beat;
  logic       in_xfer, out_fwd;
  logic       in_last_acc, eng_last;

  sm4_rr_arb2 u_rr (
    .req        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  // Configuration and input beat of the candidate / current owner.
  always_comb begin
    grant_cfg = grant ? sm4_cfg_t'{key: s1_key, sel: s1_sel}
                      : sm4_cfg_t'{key: s0_key, sel: s0_sel};
    src_beat  = owner_q
      ? axis_beat_t'{tdata: s1_axis_tdata, tvalid: s1_axis_tvalid,
                     tlast: s1_axis_tlast, tuser: s1_axis_tuser}
      : axis_beat_t'{tdata: s0_axis_tdata, tvalid: s0_axis_tvalid,
                     tlast: s0_axis_tlast, tuser: s0_axis_tuser};
  end

  assign in_xfer     = (state_q == ST_XFER);
  assign out_fwd     = in_xfer || (state_q == ST_DRAIN);
  assign in_last_acc = in_xfer && src_beat.tvalid && src_beat.tlast && e_s_axis_tready;
  assign eng_last    = e_m_axis_tvalid && e_m_axis_tlast;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cfg_d         = cfg_q;
    loaded_cfg_d  = loaded_cfg_q;
    cfg_valid_d   = cfg_valid_q;
    settle_cnt_d  = settle_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    e_sm4_vld_d   = 1'b0;
    e_sm4_key_d   = e_sm4_key_q;
    e_sm4_sel_d   = e_sm4_sel_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant;
          cfg_d   = grant_cfg;
          if (cfg_valid_q && (grant_cfg == loaded_cfg_q)) begin
            state_d = ST_XFER;
          end else begin
            // Key pulse is registered so it coincides with the LOAD cycle.
            state_d     = ST_LOAD;
            e_sm4_vld_d = 1'b1;
            e_sm4_key_d = grant_cfg.key;
            e_sm4_sel_d = grant_cfg.sel;
          end
        end
      end
      ST_LOAD: begin
        loaded_cfg_d = cfg_q;
        cfg_valid_d  = 1'b1;
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_XFER;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
        end
      end
      ST_XFER: begin
        if (in_last_acc) begin
          if (eng_last) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (eng_last) begin
          state_d      = ST_IDLE;
          last_grant_d = owner_q;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          // Engine state is unknown after a lost packet; force a reload.
          state_d       = ST_IDLE;
          last_grant_d  = owner_q;
          timeout_err_d = 1'b1;
          cfg_valid_d   = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cfg_q         <= '0;
      loaded_cfg_q  <= '0;
      cfg_valid_q   <= 1'b0;
      settle_cnt_q  <= '0;
      drain_cnt_q   <= '0;
      e_sm4_vld_q   <= 1'b0;
      e_sm4_key_q   <= '0;
      e_sm4_sel_q   <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cfg_q         <= cfg_d;
      loaded_cfg_q  <= loaded_cfg_d;
      cfg_valid_q   <= cfg_valid_d;
      settle_cnt_q  <= settle_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      e_sm4_vld_q   <= e_sm4_vld_d;
      e_sm4_key_q   <= e_sm4_key_d;
      e_sm4_sel_q   <= e_sm4_sel_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign e_sm4_vld   = e_sm4_vld_q;
  assign e_sm4_key   = e_sm4_key_q;
  assign e_sm4_sel   = e_sm4_sel_q;

  // Stream mux into the engine and demux of its output to the owner.
  always_comb begin
    e_s_axis_tdata  = '0;
    e_s_axis_tvalid = 1'b0;
    e_s_axis_tlast  = 1'b0;
    e_s_axis_tuser  = '0;
    s0_axis_tready  = 1'b0;
    s1_axis_tready  = 1'b0;
    m0_axis_tdata   = '0;
    m0_axis_tvalid  = 1'b0;
    m0_axis_tlast   = 1'b0;
    m0_axis_tuser   = '0;
    m1_axis_tdata   = '0;
    m1_axis_tvalid  = 1'b0;
    m1_axis_tlast   = 1'b0;
    m1_axis_tuser   = '0;

    if (in_xfer) begin
      e_s_axis_tdata  = src_beat.tdata;
      e_s_axis_tvalid = src_beat.tvalid;
      e_s_axis_tlast  = src_beat.tlast;
      e_s_axis_tuser  = src_beat.tuser;
      if (owner_q) s1_axis_tready = e_s_axis_tready;
      else         s0_axis_tready = e_s_axis_tready;
    end

    if (out_fwd) begin
      if (owner_q) begin
        m1_axis_tdata  = e_m_axis_tdata;
        m1_axis_tvalid = e_m_axis_tvalid;
        m1_axis_tlast  = e_m_axis_tlast;
        m1_axis_tuser  = e_m_axis_tuser;
      end else begin
        m0_axis_tdata  = e_m_axis_tdata;
        m0_axis_tvalid = e_m_axis_tvalid;
        m0_axis_tlast  = e_m_axis_tlast;
        m0_axis_tuser  = e_m_axis_tuser;
      end
    end
  end

endmodule

// File: tb/tb_sm4_eth_arbiter.sv
// Directed bench for sm4_eth_arbiter with KEY_SETTLE=4, DRAIN_TIMEOUT=8.
// A one-cycle-latency engine stand-in XORs data with 8'h5A and echoes
// tlast/tuser; sources replay byte packets; monitors log event cycles.
module tb_sm4_eth_arbiter;

  logic         clk, rst_n;
  logic [127:0] s_key [2];
  logic         s_sel [2];
  logic [7:0]   s_tdata [2];
  logic         s_tvalid [2];
  logic         s_tlast [2];
  logic [7:0]   s_tuser [2];
  logic         s0_tready, s1_tready;
  logic [7:0]   m0_tdata, m1_tdata, m0_tuser, m1_tuser;
  logic         m0_tvalid, m1_tvalid, m0_tlast, m1_tlast;
  logic         e_vld, e_sel;
  logic [127:0] e_key;
  logic [7:0]   es_tdata, es_tuser;
  logic         es_tvalid, es_tlast, eng_rdy;
  logic [7:0]   em_tdata, em_tuser;
  logic         em_tvalid, em_tlast;
  logic         owner, busy, timeout_err;

  sm4_eth_arbiter #(.KEY_SETTLE(4), .DRAIN_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_key(s_key[0]), .s0_sel(s_sel[0]), .s1_key(s_key[1]), .s1_sel(s_sel[1]),
    .s0_axis_tdata(s_tdata[0]), .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tlast(s_tlast[0]),
    .s0_axis_tuser(s_tuser[0]), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s_tdata[1]), .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tlast(s_tlast[1]),
    .s1_axis_tuser(s_tuser[1]), .s1_axis_tready(s1_tready),
    .m0_axis_tdata(m0_tdata), .m0_axis_tvalid(m0_tvalid), .m0_axis_tlast(m0_tlast),
    .m0_axis_tuser(m0_tuser),
    .m1_axis_tdata(m1_tdata), .m1_axis_tvalid(m1_tvalid), .m1_axis_tlast(m1_tlast),
    .m1_axis_tuser(m1_tuser),
    .e_sm4_vld(e_vld), .e_sm4_key(e_key), .e_sm4_sel(e_sel),
    .e_s_axis_tdata(es_tdata), .e_s_axis_tvalid(es_tvalid), .e_s_axis_tlast(es_tlast),
    .e_s_axis_tuser(es_tuser), .e_s_axis_tready(eng_rdy),
    .e_m_axis_tdata(em_tdata), .e_m_axis_tvalid(em_tvalid), .e_m_axis_tlast(em_tlast),
    .e_m_axis_tuser(em_tuser),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K0  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] K0B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211;
  localparam logic [127:0] K1  = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] KA  = 128'h0000_0000_0000_0000_0000_0000_0000_00AA;
  localparam logic [127:0] KB  = 128'h0000_0000_0000_0000_0000_0000_0000_00BB;

  int n_cmp = 0;
  int n_bad = 0;

  // Source driver state
  int         pend [2];
  int         plen [2];
  int         idx  [2];
  logic [7:0] seed [2];
  logic       eng_no_last;

  // Monitor state (cleared per phase)
  int           cyc, vld_cnt, first_vld, to_cnt, to_cyc, busy_cyc;
  int           rise_cnt [2];
  int           first_rise [2];
  int           rise2_0;
  int           mbeats [2];
  int           mlast_cyc [2];
  int           misroute, data_err, mirror_err, ord_n;
  logic [7:0]   ord;
  logic [127:0] vld_key;
  logic [1:0]   prev_rdy;
  logic [7:0]   q0 [$];
  logic [7:0]   q1 [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < 2; k++) begin
      s_tvalid[k] = (pend[k] != 0);
      s_tdata[k]  = seed[k] + 8'(idx[k]);
      s_tlast[k]  = (pend[k] != 0) && (idx[k] == plen[k] - 1);
      s_tuser[k]  = 8'hC0 | 8'(k);
    end
  endtask

  task automatic clr_stats();
    cyc = 0; vld_cnt = 0; first_vld = -1; to_cnt = 0; to_cyc = -1; busy_cyc = -1;
    rise2_0 = -1; misroute = 0; data_err = 0; mirror_err = 0; ord_n = 0; ord = 8'h00;
    vld_key = '0; prev_rdy = 2'b00;
    for (int k = 0; k < 2; k++) begin
      rise_cnt[k] = 0; first_rise[k] = -1; mbeats[k] = 0; mlast_cyc[k] = -1;
    end
  endtask

  task automatic mon_m(input int k, input logic v, input logic l, input logic [7:0] d,
                       input logic [7:0] u);
    logic [7:0] e;
    if (v) begin
      mbeats[k]++;
      if (l) mlast_cyc[k] = cyc;
      if (u[0] != k[0]) misroute++;
      if (k == 0) begin
        if (q0.size() == 0) data_err++;
        else begin e = q0.pop_front(); if (e != d) data_err++; end
      end else begin
        if (q1.size() == 0) data_err++;
        else begin e = q1.pop_front(); if (e != d) data_err++; end
      end
    end
  endtask

  // One clock: sample at negedge+1, step to next negedge, update engine and sources.
  task automatic tick();
    logic [1:0] rdy;
    logic       eacc, el;
    logic [7:0] ed, eu;
    #1;
    if (e_vld) begin
      vld_cnt++; vld_key = e_key;
      if (first_vld < 0) first_vld = cyc;
    end
    if (timeout_err) begin to_cnt++; to_cyc = cyc; end
    if (busy) busy_cyc = cyc;
    rdy = {s1_tready, s0_tready};
    for (int k = 0; k < 2; k++) begin
      if (rdy[k] && !prev_rdy[k]) begin
        rise_cnt[k]++;
        if (first_rise[k] < 0) first_rise[k] = cyc;
        if (k == 0 && rise_cnt[k] == 2) rise2_0 = cyc;
      end
      if (rdy[k] && !eng_rdy) mirror_err++;
    end
    if (rdy == 2'b11) mirror_err++;
    prev_rdy = rdy;
    mon_m(0, m0_tvalid, m0_tlast, m0_tdata, m0_tuser);
    mon_m(1, m1_tvalid, m1_tlast, m1_tdata, m1_tuser);
    for (int k = 0; k < 2; k++) begin
      if (s_tvalid[k] && rdy[k]) begin
        if (k == 0) q0.push_back(s_tdata[k] ^ 8'h5A);
        else        q1.push_back(s_tdata[k] ^ 8'h5A);
        if (s_tlast[k]) begin
          pend[k]--; idx[k] = 0; ord = {ord[6:0], k[0]}; ord_n++;
        end else begin
          idx[k]++;
        end
      end
    end
    eacc = es_tvalid && eng_rdy; ed = es_tdata; el = es_tlast; eu = es_tuser;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    em_tvalid = eacc;
    em_tdata  = ed ^ 8'h5A;
    em_tlast  = eacc && el && !eng_no_last;
    em_tuser  = eu;
    drive_src();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic src_reset();
    for (int k = 0; k < 2; k++) begin pend[k] = 0; idx[k] = 0; plen[k] = 1; end
    q0.delete(); q1.delete();
    em_tvalid = 1'b0; em_tlast = 1'b0; em_tdata = '0; em_tuser = '0;
    eng_no_last = 1'b0; eng_rdy = 1'b1;
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_reset();
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    seed[0] = 8'h10; seed[1] = 8'h80;
    s_key[0] = K0; s_sel[0] = 1'b0; s_key[1] = K1; s_sel[1] = 1'b0;
    src_reset();
    clr_stats();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  128'(busy), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_vld",   128'(e_vld), 128'(0));
    chk("rst_key",   e_key, 128'(0));
    chk("rst_to",    128'(timeout_err), 128'(0));
    chk("rst_esv",   128'(es_tvalid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic grant, s0 16 bytes with K0
    clr_stats();
    s_key[0] = K0; s_sel[0] = 1'b0; pend[0] = 1; plen[0] = 16;
    drive_src();
    ticks(30);
    chk("t1_vld_cyc",   128'(first_vld), 128'(1));
    chk("t1_vld_cnt",   128'(vld_cnt), 128'(1));
    chk("t1_vld_key",   vld_key, K0);
    chk("t1_rdy_cyc",   128'(first_rise[0]), 128'(6));
    chk("t1_m0_beats",  128'(mbeats[0]), 128'(16));
    chk("t1_m1_beats",  128'(mbeats[1]), 128'(0));
    chk("t1_m0_last",   128'(mlast_cyc[0]), 128'(22));
    chk("t1_busy_last", 128'(busy_cyc), 128'(22));
    chk("t1_data",      128'(data_err), 128'(0));

    // 2: round-robin after reset, both request with different keys
    do_reset();
    clr_stats();
    s_key[0] = KA; s_sel[0] = 1'b0; pend[0] = 2; plen[0] = 4;
    s_key[1] = KB; s_sel[1] = 1'b1; pend[1] = 2; plen[1] = 4;
    drive_src();
    ticks(60);
    chk("t2_ord_n",    128'(ord_n), 128'(4));
    chk("t2_order",    128'(ord), 128'(8'h05));
    chk("t2_vld_cnt",  128'(vld_cnt), 128'(4));
    chk("t2_misroute", 128'(misroute), 128'(0));
    chk("t2_m0_beats", 128'(mbeats[0]), 128'(8));
    chk("t2_m1_beats", 128'(mbeats[1]), 128'(8));
    chk("t2_data",     128'(data_err), 128'(0));

    // 3: load skip on back-to-back packets, then key change forces load
    clr_stats();
    s_key[0] = K0; s_sel[0] = 1'b0; pend[0] = 2; plen[0] = 3;
    drive_src();
    ticks(20);
    chk("t3_vld_cnt",   128'(vld_cnt), 128'(1));
    chk("t3_rise_cnt",  128'(rise_cnt[0]), 128'(2));
    chk("t3_skip_rdy",  128'(rise2_0), 128'(11));
    clr_stats();
    s_key[0] = K0B; pend[0] = 1; plen[0] = 3;
    drive_src();
    ticks(15);
    chk("t3_reload_cnt", 128'(vld_cnt), 128'(1));
    chk("t3_reload_key", vld_key, K0B);
    chk("t3_reload_cyc", 128'(first_vld), 128'(1));

    // 4: engine backpressure mid-packet while s1 waits
    clr_stats();
    pend[0] = 1; plen[0] = 8;
    drive_src();
    ticks(2);
    s_key[1] = K1; s_sel[1] = 1'b0; pend[1] = 1; plen[1] = 4;
    drive_src();
    ticks(2);
    eng_rdy = 1'b0;
    ticks(5);
    eng_rdy = 1'b1;
    ticks(25);
    chk("t4_m0_beats",  128'(mbeats[0]), 128'(8));
    chk("t4_m0_last",   128'(mlast_cyc[0]), 128'(14));
    chk("t4_mirror",    128'(mirror_err), 128'(0));
    chk("t4_vld_cnt",   128'(vld_cnt), 128'(1));
    chk("t4_vld_cyc",   128'(first_vld), 128'(16));
    chk("t4_s1_rdy",    128'(first_rise[1]), 128'(21));
    chk("t4_data",      128'(data_err), 128'(0));
    chk("t4_q_empty",   128'(q0.size() + q1.size()), 128'(0));

    // 5: drain timeout with engine never signalling tlast
    clr_stats();
    eng_no_last = 1'b1;
    pend[0] = 1; plen[0] = 2;
    drive_src();
    ticks(20);
    chk("t5_to_cnt",    128'(to_cnt), 128'(1));
    chk("t5_to_cyc",    128'(to_cyc), 128'(16));
    chk("t5_busy_last", 128'(busy_cyc), 128'(15));
    chk("t5_m0_beats",  128'(mbeats[0]), 128'(2));
    eng_no_last = 1'b0;
    clr_stats();
    pend[0] = 1; plen[0] = 2;
    drive_src();
    ticks(15);
    chk("t5_reload_cnt", 128'(vld_cnt), 128'(1));
    chk("t5_no_to",      128'(to_cnt), 128'(0));

    // 6: asynchronous reset while s1 is in XFER
    clr_stats();
    pend[1] = 1; plen[1] = 8;
    drive_src();
    ticks(8);
    chk("t6_pre_owner", 128'(owner), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_owner",  128'(owner), 128'(0));
    chk("t6_busy",   128'(busy), 128'(0));
    chk("t6_key",    e_key, 128'(0));
    chk("t6_s1rdy",  128'(s1_tready), 128'(0));
    chk("t6_esv",    128'(es_tvalid), 128'(0));
    chk("t6_m1v",    128'(m1_tvalid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    src_reset();
    clr_stats();
    rst_n = 1'b1;
    pend[0] = 1; plen[0] = 4; pend[1] = 1; plen[1] = 4;
    drive_src();
    ticks(30);
    chk("t6_vld_cyc", 128'(first_vld), 128'(1));
    chk("t6_vld_key", vld_key, K1);
    chk("t6_s0_rdy",  128'(first_rise[0]), 128'(6));
    chk("t6_order",   128'(ord), 128'(8'h01));
    chk("t6_ord_n",   128'(ord_n), 128'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sm4_eth_arbiter.md
# sm4_eth_arbiter

Packet-level scheduler that shares one `sm4_top_eth_support` byte-stream engine between two Ethernet requesters. Each requester has its own key and encrypt/decrypt select. Per packet, the block grants one requester round-robin and reloads the engine key only when the configuration changes. It forwards that requester's AXI-Stream packet into the engine, then routes the engine output back to the same requester until the output `tlast`. It sits between the two MAC-side stream ports and the single engine instance.

## Interface
Parameters:
- `KEY_SETTLE`, 4: idle cycles after the key-load pulse before the first data beat; range 1..255.
- `DRAIN_TIMEOUT`, 4096: maximum cycles in DRAIN waiting for engine output `tlast`; range 2..65535.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `s0_key`, `s1_key` in 128: per-requester key, sampled at grant.
- `s0_sel`, `s1_sel` in 1: per-requester mode, 0 = encrypt, 1 = decrypt; sampled at grant.
- `sN_axis_tdata` in 8, `sN_axis_tvalid` in 1, `sN_axis_tlast` in 1, `sN_axis_tuser` in 8, `sN_axis_tready` out 1: requester input streams, N = 0, 1.
- `mN_axis_tdata` out 8, `mN_axis_tvalid` out 1, `mN_axis_tlast` out 1, `mN_axis_tuser` out 8: requester result streams. These have no backpressure.
- `e_sm4_vld` out 1, `e_sm4_key` out 128, `e_sm4_sel` out 1: engine key-load controls.
- `e_s_axis_*` out (`tdata`, `tvalid`, `tlast`, `tuser`) and `e_s_axis_tready` in: engine input.
- `e_m_axis_*` in (`tdata`, `tvalid`, `tlast`, `tuser`): engine output.
- `owner` out 1: currently granted requester.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: one-cycle pulse on drain timeout.

## Operation
- FSM states are IDLE, LOAD, SETTLE, XFER and DRAIN.
- **IDLE:**
  - Requests are `s0_axis_tvalid` and `s1_axis_tvalid`.
  - Round-robin: the requester other than `last_grant` wins when both request. A lone requester always wins.
  - On a grant, register `owner`, key and sel.
  - If `cfg_valid` is set and the {key, sel} of `owner` equals `loaded_cfg`, go to XFER. Otherwise go to LOAD.
- **LOAD:**
  - Drive `e_sm4_vld` = 1 for exactly one cycle, with `e_sm4_key` and `e_sm4_sel` set to the latched values.
  - Set `loaded_cfg` and `cfg_valid`, then go to SETTLE.
- **SETTLE:** count `KEY_SETTLE` cycles, then go to XFER.
- **XFER:**
  - `e_s_axis_*` is driven from `s[owner]_axis_*`.
  - `s[owner]_axis_tready` = `e_s_axis_tready`. The non-owner `tready` is 0.
  - An accepted beat with `tlast` moves the FSM to DRAIN. If `e_m_axis_tvalid & e_m_axis_tlast` occurs in the same cycle, the FSM goes straight to IDLE instead.
- **DRAIN:**
  - The input side is blocked.
  - The first engine output beat with `tvalid & tlast` moves the FSM to IDLE.
  - `drain_cnt` reaching `DRAIN_TIMEOUT` − 1 pulses `timeout_err`, clears `cfg_valid` and moves the FSM to IDLE.
- **Exit to IDLE:** every exit from DRAIN/XFER to IDLE sets `last_grant` = `owner`.
- **Output demux:**
  - In XFER and DRAIN, `e_m_axis_*` is forwarded combinationally to `m[owner]_axis_*`.
  - The other requester's `tvalid` and `tlast` are 0.
  - In IDLE, LOAD and SETTLE, engine output beats are dropped and all `mN_axis_tvalid` are 0.
- `e_s_axis_tvalid` = 0 outside XFER.

## Timing
- **Reset values:**
  - State IDLE; `owner` 0; `last_grant` 1, so requester 0 wins first.
  - `cfg_valid` 0; `loaded_cfg` 0; `e_sm4_vld` 0; `e_sm4_key` 0; `e_sm4_sel` 0.
  - All `tready`, `tvalid`, `tlast`, `busy` and `timeout_err` are 0. Data outputs are 0.
- **Grant latency:** a request in IDLE at cycle t gives:
  - t+1: LOAD, with `e_sm4_vld` high.
  - t+2 .. t+1+`KEY_SETTLE`: SETTLE.
  - t+2+`KEY_SETTLE`: first possible `tready`.
- **Grant latency, load skipped:** XFER at t+1.
- **IDLE dwell:** one cycle minimum between packets.
- **Registered outputs:** `e_sm4_vld`, `e_sm4_key` and `e_sm4_sel` are registered. `e_sm4_key` and `e_sm4_sel` hold their value between loads.
- **Combinational paths:** `tready`, stream muxes and demuxes are combinational from state and `owner`.
- **Key change during a packet:** a requester key change while that requester is granted has no effect until its next grant.
- **Reset mid-packet:** immediate return to IDLE and `cfg_valid` = 0, so the next grant always performs LOAD.
- `drain_cnt` is 16 bits and is cleared on DRAIN entry.

## Structure
- Shared package `sm4_arb_pkg`: the state encoding enum (5 states, 3 bits) and the `SM4_CFG_W` = 129 constant.
- One sub-module: `sm4_rr_arb2`, a 2-requester round-robin picker (`req[1:0]`, `last_grant` → `grant`, `grant_vld`), purely combinational.
- The rest is in `sm4_eth_arbiter`: FSM, counters, config compare, muxes.

## Test plan
1. **Basic grant:** after reset, s0 sends a 16-byte packet with key K0, sel 0.
   - `e_sm4_vld` pulses once at t+1 with key K0.
   - First `s0_axis_tready` at t+2+`KEY_SETTLE`.
   - Engine output appears only on `m0`; `busy` falls after `m0` `tlast`.
2. **Round-robin:** s0 and s1 request simultaneously with different keys.
   - Grant order is s0, s1, s0, s1.
   - Each switch produces a new `e_sm4_vld` pulse; `m1_axis_tvalid` stays 0 during s0 packets.
3. **Load skip:** s0 sends two back-to-back packets with an unchanged key.
   - The second packet gets no `e_sm4_vld` and reaches XFER one cycle after IDLE.
   - A changed key (K0 → K0′) on a third packet forces LOAD.
4. **Backpressure and drain:** hold `e_s_axis_tready` low for 5 cycles mid-packet.
   - No beats are lost; `s0_axis_tready` mirrors the engine.
   - No new grant occurs before the engine output `tlast`, even while s1 is requesting.
5. **Timeout:** `DRAIN_TIMEOUT` = 8 and the engine never asserts output `tlast`.
   - `timeout_err` pulses exactly 8 cycles after DRAIN entry; the FSM returns to IDLE.
   - The next grant performs LOAD.
6. **Reset:** deassert `rst_n` in XFER.
   - All outputs go to reset values asynchronously.
   - After release, the first grant goes to s0 and includes LOAD.
